aes_round_scheduler: RTL and testbench

Sequences one AES-style encryption block through the shared round datapath (dynamic ShiftRows plus bit-permuted MixColumns) using the round keys produced by the LFSR key generator.
- Accepts a plaintext block over a valid/ready handshake and performs the round-0 AddRoundKey internally.
- Issues rounds 1..NR to the datapath one at a time, each with its round key, round index and last-round flag.
- Returns the ciphertext over a valid/ready handshake.
- Guards every datapath round with a watchdog timeout.

---
 rtl/aes_round_scheduler_if.sv | 32 +++
 rtl/aes_round_scheduler.sv | 107 ++++++++++
 tb/tb_aes_round_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_scheduler_if.sv
// Handshake and datapath bundle for the AES round scheduler.
// master: the scheduler side. slave: the plaintext source, the round datapath
// and the ciphertext consumer.
interface aes_round_scheduler_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;

  logic         dp_load;
  logic [127:0] dp_state;
  logic [127:0] dp_round_key;
  logic [3:0]   dp_round_idx;
  logic         dp_last;
  logic         dp_done;
  logic [127:0] dp_result;

  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  modport master (
    input  in_valid, in_block, dp_done, dp_result, out_ready,
    output in_ready, dp_load, dp_state, dp_round_key, dp_round_idx, dp_last,
           out_valid, out_block
  );

  modport slave (
    output in_valid, in_block, dp_done, dp_result, out_ready,
    input  in_ready, dp_load, dp_state, dp_round_key, dp_round_idx, dp_last,
           out_valid, out_block
  );
endinterface

// File: rtl/aes_round_scheduler.sv
// AES round scheduler: accepts one plaintext block, applies the whitening key,
// walks rounds 1..NR through the shared round datapath and returns the
// ciphertext. Every datapath round is guarded by a watchdog.
module aes_round_scheduler #(
  parameter int NR         = 10,
  parameter int DP_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_an,
  input  logic                    keys_ready,
  input  logic [128*(NR+1)-1:0]   keys_flat,
  aes_round_scheduler_if.master   bus,
  output logic                    busy,
  output logic                    err
);

  localparam int           WD_W = $clog2(DP_TIMEOUT) + 1;
  localparam logic [3:0]   NR_L = 4'(NR);
  // Counter is 0 in the first WAIT_DP cycle, so abort is decided when it
  // holds DP_TIMEOUT-2; err then becomes visible DP_TIMEOUT cycles after dp_load.
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(DP_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DP, OUTPUT} state_t;

  state_t          fsm;
  logic [WD_W-1:0] wdog;
  logic [3:0]      nxt_round;

  // Round key k lives at bits [128k+127:128k].
  function automatic logic [127:0] key_at(input logic [3:0] k);
    return keys_flat[128*int'(k) +: 128];
  endfunction

  // Acceptance is only possible from IDLE with a valid key bank.
  assign bus.in_ready = (fsm == IDLE) && keys_ready;
  assign nxt_round    = bus.dp_round_idx + 4'd1;

  // Round sequencer; dp_state doubles as the running cipher state, and
  // dp_round_idx doubles as the round counter.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      fsm              <= IDLE;
      wdog             <= '0;
      bus.dp_load      <= 1'b0;
      bus.dp_state     <= '0;
      bus.dp_round_key <= '0;
      bus.dp_round_idx <= '0;
      bus.dp_last      <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_block    <= '0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      bus.dp_load <= 1'b0;
      err         <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.dp_state     <= bus.in_block ^ key_at(4'd0);
            bus.dp_round_key <= key_at(4'd1);
            bus.dp_round_idx <= 4'd1;
            bus.dp_last      <= (NR_L == 4'd1);
            bus.dp_load      <= 1'b1;
            busy             <= 1'b1;
            fsm              <= ISSUE;
          end
        end
        ISSUE: begin
          wdog <= '0;
          fsm  <= WAIT_DP;
        end
        WAIT_DP: begin
          if (bus.dp_done) begin
            bus.dp_state <= bus.dp_result;
            if (bus.dp_round_idx == NR_L) begin
              bus.out_block <= bus.dp_result;
              bus.out_valid <= 1'b1;
              fsm           <= OUTPUT;
            end else begin
              bus.dp_round_idx <= nxt_round;
              bus.dp_round_key <= key_at(nxt_round);
              bus.dp_last      <= (nxt_round == NR_L);
              bus.dp_load      <= 1'b1;
              fsm              <= ISSUE;
            end
          end else if (wdog == WD_LIM) begin
            // Datapath went silent: drop the block.
            err  <= 1'b1;
            busy <= 1'b0;
            fsm  <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            fsm           <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: a datapath responder with programmable latency,
// an in-bench reference model of the whole round chain, and directed scenarios.
module tb_aes_round_scheduler;
  localparam int NR = 10;
  localparam int DP_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  logic keys_ready = 1'b0;
  logic [128*(NR+1)-1:0] keys_flat = '0;
  logic busy, err;

  aes_round_scheduler_if ifc();

  aes_round_scheduler #(.NR(NR), .DP_TIMEOUT(DP_TIMEOUT)) dut (
    .clk(clk), .rst_an(rst_an), .keys_ready(keys_ready), .keys_flat(keys_flat),
    .bus(ifc.master), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Bench controls (written by the main sequence only).
  logic [127:0] key_arr [0:NR];
  int  dp_lat = 3;
  bit  dp_scr = 1'b0;
  int  mute_round = 0;
  int  stray_round = 0;
  logic od_done = 1'b0;
  logic [127:0] od_res = '0;

  // Responder outputs.
  logic resp_done = 1'b0;
  logic [127:0] resp_res = '0;
  assign ifc.dp_done   = resp_done | od_done;
  assign ifc.dp_result = od_done ? od_res : resp_res;

  // Reference model state (written by the compare process only).
  bit m_act = 1'b0;
  int m_r = 0;
  int m_L = 0;
  bit m_timed = 1'b0;
  logic [127:0] m_st [1:NR];
  logic [127:0] m_ct;
  logic [127:0] ms;
  int acc_cyc = 0, load_cyc = 0, err_cyc = 0, err_cnt = 0, ov_rise_cnt = 0, loads_cnt = 0;
  logic [127:0] first_st = '0, last_ct = '0, prev_ob = '0;
  bit prev_ov = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behaviour of the bench's datapath: identity, or a rotate/xor scramble.
  function automatic logic [127:0] dp_f(input logic [127:0] s, input logic [127:0] k,
                                        input int r, input bit last, input bit scr);
    logic [127:0] t;
    if (!scr) return s;
    t = {s[119:0], s[127:120]} ^ k;
    if (!last) t[3:0] = t[3:0] ^ 4'(r);
    return t;
  endfunction

  task automatic pack_keys();
    for (int k = 0; k <= NR; k++) keys_flat[128*k +: 128] = key_arr[k];
  endtask

  // Datapath responder: answers dp_load after dp_lat cycles.
  logic [127:0] rs_st, rs_k;
  logic [3:0]   rs_r;
  logic         rs_last;
  initial begin
    @(posedge clk); #1;
    forever begin
      if (rst_an && ifc.dp_load && ifc.dp_round_idx != 4'(mute_round)) begin
        rs_st = ifc.dp_state; rs_k = ifc.dp_round_key;
        rs_r = ifc.dp_round_idx; rs_last = ifc.dp_last;
        if (int'(rs_r) == stray_round) begin
          resp_done = 1'b1; resp_res = ~rs_st;   // bogus completion during ISSUE
          @(posedge clk); #1;
          resp_done = 1'b0;
          repeat (dp_lat - 1) @(posedge clk);
        end else begin
          repeat (dp_lat) @(posedge clk);
        end
        #1;
        resp_res  = dp_f(rs_st, rs_k, int'(rs_r), rs_last, dp_scr);
        resp_done = 1'b1;
        @(posedge clk); #1;
        resp_done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Compare process: model the whole block on acceptance, then check every
  // datapath issue and the returned ciphertext against it.
  always @(negedge clk) begin
    if (!rst_an) begin
      m_act = 1'b0;
    end else begin
      if (ifc.in_valid && ifc.in_ready) begin
        ms = ifc.in_block ^ key_arr[0];
        for (int r = 1; r <= NR; r++) begin
          m_st[r] = ms;
          ms = dp_f(ms, key_arr[r], r, r == NR, dp_scr);
        end
        m_ct = ms; m_r = 1; m_act = 1'b1; acc_cyc = cyc;
        m_L = dp_lat; m_timed = (mute_round == 0);
      end
      if (ifc.dp_load) begin
        load_cyc = cyc;
        loads_cnt++;
        if (!m_act || m_r > NR) begin
          chk("unexpected_dp_load", 1'b1, 1'b0);
        end else begin
          if (m_r == 1) begin
            first_st = ifc.dp_state;
            chk("first_load_latency", 128'(cyc - acc_cyc), 128'd1);
          end
          chk("dp_round_idx", ifc.dp_round_idx, 128'(m_r));
          chk("dp_state", ifc.dp_state, m_st[m_r]);
          chk("dp_round_key", ifc.dp_round_key, key_arr[m_r]);
          chk("dp_last", ifc.dp_last, 128'(m_r == NR));
          m_r++;
        end
      end
      if (busy) chk("in_ready_while_busy", ifc.in_ready, 1'b0);
      if (ifc.out_valid && !prev_ov) begin
        ov_rise_cnt++;
        chk("out_valid_expected", 128'(m_act && m_r == NR + 1), 128'd1);
        if (m_timed) chk("out_latency", 128'(cyc - acc_cyc), 128'(1 + NR*(m_L + 1)));
      end
      if (ifc.out_valid && prev_ov) chk("out_block_hold", ifc.out_block, prev_ob);
      if (ifc.out_valid && ifc.out_ready) begin
        last_ct = ifc.out_block;
        chk("ciphertext", ifc.out_block, m_ct);
        m_act = 1'b0;
      end
      if (err) begin
        err_cnt++; err_cyc = cyc; m_act = 1'b0;
      end
    end
    prev_ov = ifc.out_valid;
    prev_ob = ifc.out_block;
  end

  task automatic send(input logic [127:0] pt);
    int n;
    @(posedge clk); #1;
    ifc.in_valid = 1'b1; ifc.in_block = pt;
    n = 0;
    while (!ifc.in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!ifc.out_valid && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) chk("out_valid_timeout", 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dp_load"}, ifc.dp_load, 1'b0);
    chk({tag, "_dp_state"}, ifc.dp_state, '0);
    chk({tag, "_dp_round_key"}, ifc.dp_round_key, '0);
    chk({tag, "_dp_round_idx"}, ifc.dp_round_idx, '0);
    chk({tag, "_dp_last"}, ifc.dp_last, 1'b0);
    chk({tag, "_out_valid"}, ifc.out_valid, 1'b0);
    chk({tag, "_out_block"}, ifc.out_block, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  logic [127:0] cap;
  int l0, e0, o0, n;

  initial begin
    ifc.in_valid = 1'b0; ifc.in_block = '0; ifc.out_ready = 1'b1;
    for (int k = 0; k <= NR; k++) key_arr[k] = {16{8'h11}};
    pack_keys();

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");
    chk("reset_in_ready", ifc.in_ready, 1'b0);
    @(posedge clk); #1;
    rst_an = 1'b1;

    // Handshake gating, then the nominal block (identity datapath, L=3)
    dp_lat = 3; dp_scr = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_block = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("gate_in_ready", ifc.in_ready, 1'b0);
      chk("gate_busy", busy, 1'b0);
    end
    l0 = loads_cnt;
    keys_ready = 1'b1; #1;
    chk("gate_in_ready_on_keys", ifc.in_ready, 1'b1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    wait_ov();
    @(posedge clk); #1;
    chk("nominal_round1_state", first_st, 128'h111013121514171619181b1a1d1c1f1e);
    chk("nominal_ciphertext", last_ct, 128'h111013121514171619181b1a1d1c1f1e);
    chk("nominal_loads", 128'(loads_cnt - l0), 128'd10);
    chk("nominal_idle_in_ready", ifc.in_ready, 1'b1);
    chk("nominal_idle_busy", busy, 1'b0);

    // Back-pressure with stray dp_done in ISSUE and in OUTPUT
    for (int k = 0; k <= NR; k++) key_arr[k] = {4{32'h0f1e2d3c ^ (32'(k) * 32'h01010101)}};
    pack_keys();
    dp_scr = 1'b1; dp_lat = 2; stray_round = 5; ifc.out_ready = 1'b0;
    l0 = loads_cnt;
    send(128'h0123456789abcdeffedcba9876543210);
    wait_ov();
    cap = ifc.out_block;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (i == 7) begin od_done = 1'b1; od_res = ~cap; end
      if (i == 8) od_done = 1'b0;
      chk("bp_out_valid", ifc.out_valid, 1'b1);
      chk("bp_out_block", ifc.out_block, cap);
      chk("bp_in_ready", ifc.in_ready, 1'b0);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", ifc.in_ready, 1'b1);
    chk("bp_release_out_valid", ifc.out_valid, 1'b0);
    chk("bp_loads", 128'(loads_cnt - l0), 128'd10);
    stray_round = 0;

    // Watchdog: round 4 is never answered
    dp_lat = 1; dp_scr = 1'b0; mute_round = 4;
    e0 = err_cnt; o0 = ov_rise_cnt;
    send(128'hdeadbeef00112233445566778899aabb);
    n = 0;
    while (err_cnt == e0 && n < 1000) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk); #1;
    chk("wd_err_count", 128'(err_cnt - e0), 128'd1);
    chk("wd_err_delay", 128'(err_cyc - load_cyc), 128'(DP_TIMEOUT));
    chk("wd_no_out_valid", 128'(ov_rise_cnt - o0), 128'd0);
    chk("wd_busy", busy, 1'b0);
    chk("wd_in_ready", ifc.in_ready, 1'b1);
    mute_round = 0;
    send(128'h00000000000000000000000000000001);
    wait_ov();
    @(posedge clk); #1;
    chk("wd_next_done", 128'(ov_rise_cnt - o0), 128'd1);

    // Asynchronous reset in round 6
    dp_lat = 4; dp_scr = 1'b1;
    e0 = err_cnt;
    send(128'hcafef00d0badc0de1234567890abcdef);
    n = 0;
    while (!(ifc.dp_load && ifc.dp_round_idx == 4'd6) && n < 500) begin @(posedge clk); #1; n++; end
    chk("rst_reached_round6", 128'(n < 500), 128'd1);
    @(posedge clk); #1;
    rst_an = 1'b0; #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rst_an = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("midrst_no_err", 128'(err_cnt - e0), 128'd0);
    l0 = loads_cnt; o0 = ov_rise_cnt;
    send(128'h55aa55aa55aa55aa0f0f0f0ff0f0f0f0);
    wait_ov();
    @(posedge clk); #1;
    chk("midrst_next_loads", 128'(loads_cnt - l0), 128'd10);
    chk("midrst_next_done", 128'(ov_rise_cnt - o0), 128'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

endmodule
